// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between instruction fetch (IF) and load/store (LS).
// One transaction in flight at a time: grant -> memory request -> response or timeout.
module mem_port_arbiter #(
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [AW-1:0]   if_addr,
  output logic            if_resp_valid,
  output logic [DW-1:0]   if_rdata,
  output logic            if_resp_err,
  input  logic            ls_req_valid,
  output logic            ls_req_ready,
  input  logic [AW-1:0]   ls_addr,
  input  logic            ls_wen,
  input  logic [DW-1:0]   ls_wdata,
  input  logic [DW/8-1:0] ls_wmask,
  output logic            ls_resp_valid,
  output logic [DW-1:0]   ls_rdata,
  output logic            ls_resp_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_resp_valid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy,
  output logic            owner
);
  localparam int MW = DW / 8;
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t          r_state, w_state_next;
  logic            w_if_grant, w_ls_grant, w_resp_ok, w_timeout;
  logic [CW-1:0]   r_cnt;
  logic            r_owner;
  logic [AW-1:0]   r_mem_addr;
  logic            r_mem_wen;
  logic [DW-1:0]   r_mem_wdata;
  logic [MW-1:0]   r_mem_wmask;
  logic            r_if_resp_valid, r_if_resp_err, r_ls_resp_valid, r_ls_resp_err;
  logic [DW-1:0]   r_if_rdata, r_ls_rdata;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Ready is gated by rst so nothing looks accepted while the block is held in reset.
  always_comb begin
    w_state_next = r_state;
    w_if_grant   = 1'b0;
    w_ls_grant   = 1'b0;
    w_resp_ok    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!rst) begin
          if (if_req_valid && ls_req_valid) begin
            if (RR_MODE != 0 && r_owner) w_if_grant = 1'b1;
            else                         w_ls_grant = 1'b1;
          end else begin
            w_if_grant = if_req_valid;
            w_ls_grant = ls_req_valid;
          end
        end
        if (w_if_grant || w_ls_grant) w_state_next = S_REQ;
      end
      S_REQ: begin
        if (mem_req_ready) w_state_next = S_RESP;
      end
      S_RESP: begin
        if (mem_resp_valid) begin
          w_resp_ok    = 1'b1;
          w_state_next = S_IDLE;
        end else if (TIMEOUT != 0 && r_cnt == CNT_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt           <= '0;
      r_owner         <= 1'b1;
      r_mem_addr      <= '0;
      r_mem_wen       <= 1'b0;
      r_mem_wdata     <= '0;
      r_mem_wmask     <= '0;
      r_if_resp_valid <= 1'b0;
      r_if_resp_err   <= 1'b0;
      r_if_rdata      <= '0;
      r_ls_resp_valid <= 1'b0;
      r_ls_resp_err   <= 1'b0;
      r_ls_rdata      <= '0;
    end else begin
      r_if_resp_valid <= 1'b0;
      r_if_resp_err   <= 1'b0;
      r_ls_resp_valid <= 1'b0;
      r_ls_resp_err   <= 1'b0;
      if (w_ls_grant) begin
        r_mem_addr  <= ls_addr;
        r_mem_wen   <= ls_wen;
        r_mem_wdata <= ls_wdata;
        r_mem_wmask <= ls_wmask;
        r_owner     <= 1'b1;
      end else if (w_if_grant) begin
        r_mem_addr  <= if_addr;
        r_mem_wen   <= 1'b0;
        r_mem_wdata <= '0;
        r_mem_wmask <= '0;
        r_owner     <= 1'b0;
      end
      if (r_state == S_REQ && mem_req_ready) r_cnt <= '0;
      else if (r_state == S_RESP)            r_cnt <= r_cnt + CW'(1);
      // Timeouts and stores both return zero data.
      if (w_resp_ok || w_timeout) begin
        if (r_owner) begin
          r_ls_resp_valid <= 1'b1;
          r_ls_resp_err   <= w_timeout;
          r_ls_rdata      <= (w_timeout || r_mem_wen) ? '0 : mem_rdata;
        end else begin
          r_if_resp_valid <= 1'b1;
          r_if_resp_err   <= w_timeout;
          r_if_rdata      <= w_timeout ? '0 : mem_rdata;
        end
      end
    end
  end

  assign if_req_ready  = w_if_grant;
  assign ls_req_ready  = w_ls_grant;
  assign if_resp_valid = r_if_resp_valid;
  assign if_resp_err   = r_if_resp_err;
  assign if_rdata      = r_if_rdata;
  assign ls_resp_valid = r_ls_resp_valid;
  assign ls_resp_err   = r_ls_resp_err;
  assign ls_rdata      = r_ls_rdata;
  assign mem_req_valid = (r_state == S_REQ);
  assign mem_addr      = r_mem_addr;
  assign mem_wen       = r_mem_wen;
  assign mem_wdata     = r_mem_wdata;
  assign mem_wmask     = r_mem_wmask;
  assign busy          = (r_state != S_IDLE);
  assign owner         = r_owner;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: instance 0 is fixed-priority, instance 1 round-robin, both TIMEOUT=8,
// sharing requester stimulus; each has a zero-wait memory returning addr-0x80000000+0x413.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, ls_req_valid, ls_wen, mem_mute, force_resp;
  logic [63:0] if_addr, ls_addr, ls_wdata;
  logic [7:0]  ls_wmask;

  logic        if_rdy[2], if_rv[2], if_err[2], ls_rdy[2], ls_rv[2], ls_err[2];
  logic        mrv[2], mwen[2], busy[2], own[2];
  logic [63:0] if_rd[2], ls_rd[2], maddr[2], mwd[2];
  logic [7:0]  mwm[2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic        r_mresp;
    logic        w_mresp;
    logic [63:0] w_mrd;

    always_ff @(posedge clk) begin
      if (rst) r_mresp <= 1'b0;
      else     r_mresp <= mrv[gi] & ~mem_mute;
    end
    assign w_mresp = r_mresp | force_resp;
    assign w_mrd   = maddr[gi] - 64'h8000_0000 + 64'h413;

    mem_port_arbiter #(.AW(64), .DW(64), .RR_MODE(gi), .TIMEOUT(8)) u_dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_ready(if_rdy[gi]), .if_addr(if_addr),
      .if_resp_valid(if_rv[gi]), .if_rdata(if_rd[gi]), .if_resp_err(if_err[gi]),
      .ls_req_valid(ls_req_valid), .ls_req_ready(ls_rdy[gi]), .ls_addr(ls_addr),
      .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
      .ls_resp_valid(ls_rv[gi]), .ls_rdata(ls_rd[gi]), .ls_resp_err(ls_err[gi]),
      .mem_req_valid(mrv[gi]), .mem_req_ready(1'b1), .mem_addr(maddr[gi]),
      .mem_wen(mwen[gi]), .mem_wdata(mwd[gi]), .mem_wmask(mwm[gi]),
      .mem_resp_valid(w_mresp), .mem_rdata(w_mrd),
      .busy(busy[gi]), .owner(own[gi])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow #2 later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          ng;
  logic        gnt[4];
  int          gcyc[4];
  logic        exp_gnt[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; if_req_valid = 0; ls_req_valid = 0; ls_wen = 0; mem_mute = 0; force_resp = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0; ls_wmask = 0;
    repeat (3) step();
    if_req_valid = 1'b1;
    #2;
    check("rst_if_ready", if_rdy[0], 1'b0);
    if_req_valid = 1'b0;
    step(); rst = 1'b0;
    #2;
    check("rst_busy", busy[0], 1'b0);
    check("rst_owner0", own[0], 1'b1);
    check("rst_owner1", own[1], 1'b1);
    check("rst_mem_valid", mrv[0], 1'b0);
    check("rst_mem_addr", maddr[0], 64'h0);
    check("rst_if_rv", if_rv[0], 1'b0);

    // IF alone, zero-wait memory
    if_req_valid = 1'b1; if_addr = 64'h8000_0000;
    #2;
    check("t1_if_ready_c0", if_rdy[0], 1'b1);
    check("t1_ls_ready_c0", ls_rdy[0], 1'b0);
    check("t1_mem_valid_c0", mrv[0], 1'b0);
    step(); if_req_valid = 1'b0; #2;
    check("t1_mem_valid_c1", mrv[0], 1'b1);
    check("t1_mem_addr", maddr[0], 64'h8000_0000);
    check("t1_mem_wen", mwen[0], 1'b0);
    step(); #2;
    check("t1_mem_valid_c2", mrv[0], 1'b0);
    check("t1_if_rv_c2", if_rv[0], 1'b0);
    step(); #2;
    check("t1_if_rv_c3", if_rv[0], 1'b1);
    check("t1_if_rdata", if_rd[0], 64'h413);
    check("t1_if_err", if_err[0], 1'b0);
    check("t1_rr_if_rv", if_rv[1], 1'b1);
    $display("txn1 IF fetch 0x80000000 -> 0x%0h", if_rd[0]);

    // Both valid together: LS first (fixed priority; owner=IF in round-robin too)
    step();
    if_req_valid = 1'b1; if_addr = 64'h8000_0100;
    ls_req_valid = 1'b1; ls_addr = 64'h8000_0200; ls_wen = 1'b0;
    #2;
    check("t2_ls_ready", ls_rdy[0], 1'b1);
    check("t2_if_ready", if_rdy[0], 1'b0);
    check("t2_rr_ls_ready", ls_rdy[1], 1'b1);
    step(); ls_req_valid = 1'b0;
    step();
    step(); #2;
    check("t2_ls_rv", ls_rv[0], 1'b1);
    check("t2_ls_rdata", ls_rd[0], 64'h613);
    check("t2_if_ready_c3", if_rdy[0], 1'b1);
    step(); if_req_valid = 1'b0;
    step();
    step(); #2;
    check("t2_if_rv", if_rv[0], 1'b1);
    check("t2_if_rdata", if_rd[0], 64'h513);
    $display("txn2 LS load 0x%0h then IF fetch 0x%0h", ls_rd[0], if_rd[0]);

    // Round-robin with both requesters always valid, starting from reset
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    if_req_valid = 1'b1; if_addr = 64'h8000_0300;
    ls_req_valid = 1'b1; ls_addr = 64'h8000_0400;
    ng = 0;
    for (int c = 0; c < 30; c++) begin
      #2;
      if (if_rdy[1]) begin gnt[ng] = 1'b0; gcyc[ng] = c; ng++; end
      else if (ls_rdy[1]) begin gnt[ng] = 1'b1; gcyc[ng] = c; ng++; end
      if (ng == 4) break;
      step();
    end
    step(); if_req_valid = 1'b0; ls_req_valid = 1'b0;
    check("t3_grants", 64'(ng), 64'd4);
    for (int i = 0; i < ng; i++) begin
      check($sformatf("t3_grant%0d_who", i), gnt[i], exp_gnt[i]);
      check($sformatf("t3_grant%0d_cyc", i), 64'(gcyc[i]), 64'(3 * i));
      $display("txn3 RR grant %0d to %s at cycle %0d", i, gnt[i] ? "LS" : "IF", gcyc[i]);
    end
    repeat (4) step();

    // LS store
    ls_req_valid = 1'b1; ls_wen = 1'b1; ls_addr = 64'h8000_1008;
    ls_wdata = 64'h1122_3344_5566_7788; ls_wmask = 8'h0F;
    #2;
    check("t4_ls_ready", ls_rdy[0], 1'b1);
    step(); ls_req_valid = 1'b0; ls_wen = 1'b0; #2;
    check("t4_mem_wen", mwen[0], 1'b1);
    check("t4_mem_wmask", mwm[0], 8'h0F);
    check("t4_mem_wdata", mwd[0], 64'h1122_3344_5566_7788);
    check("t4_mem_addr", maddr[0], 64'h8000_1008);
    step();
    step(); #2;
    check("t4_ls_rv", ls_rv[0], 1'b1);
    check("t4_ls_rdata", ls_rd[0], 64'h0);
    check("t4_ls_err", ls_err[0], 1'b0);
    $display("txn4 LS store 0x80001008 ack rdata=0x%0h", ls_rd[0]);

    // Timeout: memory never answers; S_RESP entered in cycle 2, error pulse in cycle 10
    step(); mem_mute = 1'b1;
    ls_req_valid = 1'b1; ls_addr = 64'h8000_0500;
    step(); ls_req_valid = 1'b0;
    for (int c = 2; c <= 9; c++) step();
    #2;
    check("t5_no_early_rv", ls_rv[0], 1'b0);
    check("t5_busy_c9", busy[0], 1'b1);
    step(); #2;
    check("t5_ls_rv", ls_rv[0], 1'b1);
    check("t5_ls_err", ls_err[0], 1'b1);
    check("t5_ls_rdata", ls_rd[0], 64'h0);
    check("t5_rr_ls_err", ls_err[1], 1'b1);
    force_resp = 1'b1;
    step(); force_resp = 1'b0; mem_mute = 1'b0; #2;
    check("t5_stray_rv", ls_rv[0], 1'b0);
    check("t5_stray_busy", busy[0], 1'b0);
    $display("txn5 LS load 0x80000500 timed out err=1");

    // Reset while in S_REQ aborts the transaction
    step();
    if_req_valid = 1'b1; if_addr = 64'h8000_0000;
    #2;
    check("t6_if_ready", if_rdy[0], 1'b1);
    step(); if_req_valid = 1'b0; rst = 1'b1; #2;
    check("t6_in_req", mrv[0], 1'b1);
    step(); rst = 1'b0; #2;
    check("t6_busy", busy[0], 1'b0);
    check("t6_mem_valid", mrv[0], 1'b0);
    check("t6_if_rv", if_rv[0], 1'b0);
    check("t6_mem_addr", maddr[0], 64'h0);
    step(); #2;
    check("t6_if_rv_late", if_rv[0], 1'b0);
    if_req_valid = 1'b1; if_addr = 64'h8000_0040;
    step(); if_req_valid = 1'b0;
    step();
    step(); #2;
    check("t6_refetch_rv", if_rv[0], 1'b1);
    check("t6_refetch_rdata", if_rd[0], 64'h453);
    $display("txn6 abort in S_REQ, refetch 0x80000040 -> 0x%0h", if_rd[0]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
